// File: rtl/shift_add_mult16_pkg.sv
// rtl/shift_add_mult16_pkg.sv - shared widths, state encoding and shift-step helper
package shift_add_mult16_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // One multiply iteration: keep the adder result (carry included) when the
  // multiplier LSB is set, otherwise just shift the accumulator right.
  function automatic logic [PROD_W-1:0] shift_step(
    input logic [WIDTH-1:0] acc_hi,
    input logic [WIDTH-1:0] acc_lo,
    input logic [WIDTH-1:0] sum,
    input logic             cout
  );
    if (acc_lo[0]) begin
      return {cout, sum, acc_lo[WIDTH-1:1]};
    end
    return {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/shift_add_mult16_cla.sv
// rtl/shift_add_mult16_cla.sv - 16-bit two-level carry-lookahead adder (4x4-bit groups)
module CLA_16bit (
  output logic [15:0] sum,
  output logic        cout,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [15:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  // Group carries resolved in parallel from the group generate/propagate terms.
  always_comb begin
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
  end

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
    sum  = p ^ c;
    cout = grp_c[4];
  end

endmodule

// File: rtl/shift_add_mult16.sv
// rtl/shift_add_mult16.sv - sequential 16x16 unsigned shift-add multiplier, start/done handshake
import shift_add_mult16_pkg::*;

module shift_add_mult16 (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [PROD_W-1:0]  acc_nxt;
  logic               accept;
  logic               last;

  CLA_16bit u_cla (
    .sum  (sum),
    .cout (cout),
    .a    (acc_hi),
    .b    (mcand),
    .cin  (1'b0)
  );

  assign accept  = start && (state == IDLE || state == DONE);
  assign last    = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign acc_nxt = shift_step(acc_hi, acc_lo, sum, cout);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand  <= a;
        acc_hi <= '0;
        acc_lo <= b;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc_hi <= acc_nxt[PROD_W-1:WIDTH];
        acc_lo <= acc_nxt[WIDTH-1:0];
        cnt    <= cnt + CNT_W'(1);
        // product only moves on the edge that enters DONE
        if (last) begin
          product <= acc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult16.sv
// tb/tb_shift_add_mult16.sv - self-checking bench for shift_add_mult16 against an arithmetic model
module tb_shift_add_mult16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int          tests;
  int          fails;
  logic [31:0] last_prod;

  shift_add_mult16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    a = x;
    b = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_run(input logic [31:0] exp, input string name);
    for (int i = 1; i <= 16; i++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s run E+%0d: busy=%b done=%b, need busy=1 done=0", name, i, busy, done);
      end
      if (i == 1) begin
        tests++;
        if (product !== last_prod) begin
          fails++;
          $display("FAIL %s hold: product=%h, need %h", name, product, last_prod);
        end
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done E+17: done=%b busy=%b, need done=1 busy=0", name, done, busy);
    end
    tests++;
    if (product !== exp) begin
      fails++;
      $display("FAIL %s product: got %h, need %h", name, product, exp);
    end
    last_prod = exp;
  endtask

  task automatic expect_idle(input string name);
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== last_prod) begin
      fails++;
      $display("FAIL %s idle: busy=%b done=%b product=%h, need 0 0 %h", name, busy, done, product, last_prod);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    repeat (2) step();
    rst = 1'b0;
    start = 1'b0;
    last_prod = 32'h0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b product=%h, need 0 0 0", busy, done, product);
    end
    expect_idle("reset_no_start");
  endtask

  task automatic test_basic();
    launch(16'h0003, 16'h0005);
    expect_run(32'h0000000F, "basic");
    expect_idle("basic");
  endtask

  task automatic test_carry();
    launch(16'hFFFF, 16'hFFFF);
    expect_run(32'hFFFE0001, "carry");
    expect_idle("carry");
  endtask

  task automatic test_zero_identity();
    launch(16'h0000, 16'h1234);
    expect_run(32'h00000000, "zero");
    expect_idle("zero");
    launch(16'h1234, 16'h0001);
    expect_run(32'h00001234, "identity");
    expect_idle("identity");
  endtask

  task automatic test_ignored_start();
    launch(16'h0002, 16'h0003);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        a = 16'h00FF;
        b = 16'h00FF;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL ignored_start run E+%0d: busy=%b done=%b, need 1 0", i, busy, done);
      end
      step();
    end
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || product !== 32'h00000006) begin
      fails++;
      $display("FAIL ignored_start result: done=%b product=%h, need 1 00000006", done, product);
    end
    last_prod = 32'h00000006;
    repeat (3) expect_idle("ignored_start_no_rerun");
  endtask

  task automatic test_back_to_back();
    launch(16'h0010, 16'h0010);
    expect_run(32'h00000100, "b2b_first");
    launch(16'h0100, 16'h0100);
    expect_run(32'h00010000, "b2b_second");
    expect_idle("b2b");
  endtask

  task automatic test_reset_mid_run();
    launch(16'hABCD, 16'h1357);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b product=%h, need 0 0 0", busy, done, product);
    end
    last_prod = 32'h0;
    expect_idle("reset_mid_run_quiet");
    launch(16'h0007, 16'h0009);
    expect_run(32'h0000003F, "after_reset");
    expect_idle("after_reset");
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [15:0] y;
    for (int n = 0; n < 24; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (n % 6 == 0) x = 16'hFFFF;
      if (n % 7 == 3) y = 16'h8000;
      launch(x, y);
      expect_run(model_mul(x, y), "random");
      if ($urandom_range(1, 0) == 0 || n == 23) begin
        expect_idle("random");
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    last_prod = 32'h0;
    rst = 1'b1;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    test_reset();
    test_basic();
    test_carry();
    test_zero_identity();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
